mux_scan: RTL and testbench

- Parametrised, registered N:1 word multiplexer. Next generation of the team's 4:1 single-bit structural mux.
- Generalised to WIDTH-bit data and CHANNELS inputs.
- Adds an output register, a manual/scan mode FSM, a dwell counter, and valid/wrap status.
- Sits between parallel data sources and a single shared consumer, e.g. a display or serial link driven round-robin.

---
 rtl/mux_scan.sv | 167 ++++++++++++++++
 tb/tb_mux_scan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: registered CHANNELS:1 word multiplexer with manual and scan modes.
//
// The block picks one WIDTH-bit slice of the packed input bus d and registers
// it onto y. In manual mode the slice is chosen by s. In scan mode an
// internal pointer walks the channels round-robin. It stays DWELL cycles on
// each channel and pulses wrap when it returns to the lowest channel.
// en=0 freezes the data path and the scan position.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   d       packed channel data, channel i at d[i*WIDTH +: WIDTH]
//   s       manual channel select
//   mode    0 = manual, 1 = scan
//   en      enable; 0 holds y/ch/pointer/dwell, drops valid
//   ch_mask per-channel scan/select enable (only with SCAN_MASK_EN)
//   y       registered selected data
//   ch      index of the channel currently on y
//   valid   y holds a legitimately selected channel
//   wrap    one-cycle pulse when the scan pointer wraps to a lower index
//
// Optional feature: define SCAN_MASK_EN to add the ch_mask input. Scanning
// then skips disabled channels. A manual select of a disabled channel
// behaves like an out-of-range select.

module mux_scan #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SELW-1:0]           s,
  input  logic                      mode,
  input  logic                      en,
`ifdef SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int CW = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SELW-1:0] ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_eff;
  logic [SELW-1:0] ptr_nxt;
  logic            sel_ok;
  logic            dwell_done;

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] data,
                                            input logic [SELW-1:0] idx);
    return data[int'(idx)*WIDTH +: WIDTH];
  endfunction

`ifdef SCAN_MASK_EN
  // Mask padded to the full select range so out-of-range selects read 0.
  logic [(1<<SELW)-1:0] mask_ext;
  logic                 mask_any;
  logic                 ptr_on;

  // Next enabled channel above idx, wrapping. If idx is the only enabled
  // channel the search comes back to idx itself.
  function automatic logic [SELW-1:0] next_on(input logic [SELW-1:0] idx,
                                              input logic [CHANNELS-1:0] m);
    logic [SELW-1:0] r;
    r = idx;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (m[(int'(idx) + i) % CHANNELS]) r = SELW'((int'(idx) + i) % CHANNELS);
    end
    return r;
  endfunction

  always_comb begin
    mask_ext = '0;
    mask_ext[CHANNELS-1:0] = ch_mask;
    mask_any = |ch_mask;
    ptr_on   = mask_ext[ptr];
    ptr_nxt  = next_on(ptr, ch_mask);
    sel_ok   = (int'(s) < CHANNELS) && mask_ext[s];
  end
`else
  always_comb begin
    ptr_nxt = (int'(ptr) == CHANNELS - 1) ? '0 : ptr + SELW'(1);
    sel_ok  = int'(s) < CHANNELS;
  end
`endif

  always_comb begin
    state_nxt = !en ? IDLE : (mode ? SCAN : MANUAL);
    // Coming out of manual mode the dwell restarts, even if the last manual
    // select was rejected and left cnt untouched.
    cnt_eff    = (state == MANUAL) ? '0 : cnt;
    dwell_done = cnt_eff == CW'(DWELL - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        MANUAL: begin
          wrap <= 1'b0;
          if (sel_ok) begin
            y     <= pick(d, s);
            ch    <= s;
            valid <= 1'b1;
            ptr   <= s;
            cnt   <= '0;
          end else begin
            y     <= '0;
            valid <= 1'b0;
          end
        end
        SCAN: begin
`ifdef SCAN_MASK_EN
          if (!mask_any) begin
            valid <= 1'b0;
            wrap  <= 1'b0;
          end else if (!ptr_on) begin
            // Parked on a disabled channel: hop without presenting it.
            ptr   <= ptr_nxt;
            cnt   <= '0;
            valid <= 1'b0;
            wrap  <= ptr_nxt <= ptr;
          end else
`endif
          begin
            y     <= pick(d, ptr);
            ch    <= ptr;
            valid <= 1'b1;
            if (dwell_done) begin
              cnt  <= '0;
              ptr  <= ptr_nxt;
              // An advance that does not go upward is a wrap.
              wrap <= ptr_nxt <= ptr;
            end else begin
              cnt  <= cnt_eff + CW'(1);
              wrap <= 1'b0;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;
  localparam int C  = 4;
  localparam int W  = 8;
  localparam int DW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  d;
  logic [1:0]   s;
  logic         mode, en;
  logic [7:0]   y;
  logic [1:0]   ch;
  logic         valid, wrap;

  logic [23:0]  d3;
  logic [1:0]   s3;
  logic         mode3, en3;
  logic [7:0]   y3;
  logic [1:0]   ch3;
  logic         valid3, wrap3;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(W), .CHANNELS(C), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .en(en),
`ifdef SCAN_MASK_EN
    .ch_mask(4'hF),
`endif
    .y(y), .ch(ch), .valid(valid), .wrap(wrap));

  mux_scan #(.WIDTH(W), .CHANNELS(3), .DWELL(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .s(s3), .mode(mode3), .en(en3),
`ifdef SCAN_MASK_EN
    .ch_mask(3'h7),
`endif
    .y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3));

  typedef struct {
    logic [7:0] y;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model: which channel is shown, how long it has been shown,
  // and what mode the previous cycle was in.
  int         m_ptr, m_pos, m_last, m_ch;
  logic [7:0] m_y;
  logic       m_valid, m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_pos = 0; m_last = 0; m_ch = 0;
    m_y = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
  endfunction

  function automatic void model_step(input logic e, input logic md, input int sel,
                                     input logic [31:0] dv);
    if (!e) begin
      m_valid = 1'b0; m_wrap = 1'b0; m_last = 0;
    end else if (!md) begin
      m_wrap = 1'b0; m_last = 1;
      if (sel < C) begin
        m_y = dv[sel*8 +: 8]; m_ch = sel; m_valid = 1'b1; m_ptr = sel; m_pos = 0;
      end else begin
        m_y = 8'h00; m_valid = 1'b0;
      end
    end else begin
      if (m_last == 1) m_pos = 0;
      m_last  = 2;
      m_y     = dv[m_ptr*8 +: 8];
      m_ch    = m_ptr;
      m_valid = 1'b1;
      m_wrap  = 1'b0;
      m_pos++;
      if (m_pos == DW) begin
        m_pos = 0;
        if (m_ptr == C - 1) m_wrap = 1'b1;
        m_ptr = (m_ptr + 1) % C;
      end
    end
  endfunction

  // Called at a falling edge: apply inputs for the next rising edge, queue
  // the expected outputs, then move on to the following falling edge.
  task automatic cyc(input logic e, input logic md, input logic [1:0] sel,
                     input logic [31:0] dv);
    exp_t x;
    en = e; mode = md; s = sel; d = dv;
    model_step(e, md, int'(sel), dv);
    x.y = m_y; x.ch = 2'(m_ch); x.valid = m_valid; x.wrap = m_wrap;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: every registered output after a rising edge is matched
  // against the oldest pending expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("y", 32'(y), 32'(x.y));
      chk("ch", 32'(ch), 32'(x.ch));
      chk("valid", 32'(valid), 32'(x.valid));
      chk("wrap", 32'(wrap), 32'(x.wrap));
    end
  end

  localparam logic [31:0] DPLAN = 32'h44332211;

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; s = 2'd0; d = DPLAN;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_ch", 32'(ch), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Nine scan edges from reset: 11,11,22,22,33,33,44,44(wrap),11.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 2'd0, DPLAN);
    cyc(1'b1, 1'b1, 2'd0, DPLAN);

    // Asynchronous reset between edges while scanning.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_ch", 32'(ch), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Scan to 0x22 first-dwell, freeze three cycles, resume mid-dwell.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd0, DPLAN);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd0, DPLAN);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd0, DPLAN);

    // Manual select, then hand back to scan from that channel.
    cyc(1'b1, 1'b0, 2'd2, DPLAN);
    cyc(1'b1, 1'b0, 2'd1, DPLAN);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd0, DPLAN);
    cyc(1'b1, 1'b0, 2'd3, DPLAN);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), $urandom);
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Three-channel instance: out-of-range manual select.
  initial begin
    en3 = 1'b0; mode3 = 1'b0; s3 = 2'd0; d3 = 24'h332211;
    @(posedge rst_n);
    @(negedge clk);
    en3 = 1'b1; s3 = 2'd1;
    @(posedge clk); #1;
    chk("c3_y", 32'(y3), 32'h22);
    chk("c3_ch", 32'(ch3), 32'd1);
    chk("c3_valid", 32'(valid3), 32'd1);
    @(negedge clk);
    s3 = 2'd3;
    @(posedge clk); #1;
    chk("c3_oor_y", 32'(y3), 32'h0);
    chk("c3_oor_ch", 32'(ch3), 32'd1);
    chk("c3_oor_valid", 32'(valid3), 32'd0);
    @(negedge clk);
    en3 = 1'b0;
  end

endmodule
